// File: rtl/idct_1d.sv
// Streaming 8-point 1-D inverse DCT: eight coefficients in natural order k=0..7,
// then eight saturated spatial samples n=0..7 on consecutive cycles.
module idct_1d #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 9,
  parameter int FRAC  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_in,
  input  logic signed [IN_W-1:0]  X_in,
  output logic                    valid_out,
  output logic                    sop_out,
  output logic signed [OUT_W-1:0] x_out
);

  localparam int CW = 11;
  localparam int PW = IN_W + CW;
  localparam int AW = PW + 3;

  localparam logic signed [AW-1:0]    ROUND   = AW'(1) << (FRAC - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [AW-1:0]    LIM_HI  = AW'(OUT_MAX);
  localparam logic signed [AW-1:0]    LIM_LO  = AW'(OUT_MIN);

  // COS_TAB[n][k] = round(2^FRAC * w_k * cos((2n+1)k*pi/16)), w_0 = 1/(2*sqrt2), w_k = 1/2
  localparam logic signed [CW-1:0] COS_TAB [8][8] = '{
    '{11'sd181,  11'sd251,  11'sd237,  11'sd213,  11'sd181,  11'sd142,  11'sd98,   11'sd50},
    '{11'sd181,  11'sd213,  11'sd98,  -11'sd50,  -11'sd181, -11'sd251, -11'sd237, -11'sd142},
    '{11'sd181,  11'sd142, -11'sd98,  -11'sd251, -11'sd181,  11'sd50,   11'sd237,  11'sd213},
    '{11'sd181,  11'sd50,  -11'sd237, -11'sd142,  11'sd181,  11'sd213, -11'sd98,  -11'sd251},
    '{11'sd181, -11'sd50,  -11'sd237,  11'sd142,  11'sd181, -11'sd213, -11'sd98,   11'sd251},
    '{11'sd181, -11'sd142, -11'sd98,   11'sd251, -11'sd181, -11'sd50,   11'sd237, -11'sd213},
    '{11'sd181, -11'sd213,  11'sd98,   11'sd50,  -11'sd181,  11'sd251, -11'sd237,  11'sd142},
    '{11'sd181, -11'sd251,  11'sd237, -11'sd213,  11'sd181, -11'sd142,  11'sd98,  -11'sd50}
  };

  logic [2:0]               k_q, k_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     sop_q, sop_d;
  logic signed [OUT_W-1:0]  bank_q [8];
  logic signed [OUT_W-1:0]  bank_d [8];
  logic signed [OUT_W-1:0]  samp [8];
  logic                     load;

  assign load = ena_in && (k_q == 3'd7);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_q, acc_d, sum, shifted;

    assign prod    = PW'(X_in) * PW'(COS_TAB[gi][k_q]);
    assign sum     = acc_q + AW'(prod);
    assign shifted = (sum + ROUND) >>> FRAC;
    assign samp[gi] = (shifted > LIM_HI) ? OUT_MAX :
                      (shifted < LIM_LO) ? OUT_MIN : shifted[OUT_W-1:0];

    // k=0 overwrites the accumulator so no clear cycle is needed between blocks
    always_comb begin
      acc_d = acc_q;
      if (ena_in) begin
        acc_d = (k_q == 3'd0) ? AW'(prod) : sum;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

  always_comb begin
    k_d     = ena_in ? k_q + 3'd1 : k_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    bank_d  = bank_q;
    // a fresh block wins over the retiring x[7], so back-to-back blocks stream without a gap
    if (load) begin
      bank_d  = samp;
      cnt_d   = 4'd8;
      valid_d = 1'b1;
      sop_d   = 1'b1;
    end else if (cnt_q > 4'd1) begin
      for (int i = 0; i < 7; i++) begin
        bank_d[i] = bank_q[i+1];
      end
      cnt_d   = cnt_q - 4'd1;
      valid_d = 1'b1;
    end else begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      bank_q  <= bank_d;
    end
  end

  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign x_out     = bank_q[0];

endmodule

// File: tb/tb_idct_1d.sv
// Bench for idct_1d: real-valued cosine model predicts each output cycle; directed
// blocks cover DC, AC, saturation, gapped input, back-to-back and mid-stream reset.
module tb_idct_1d;

  localparam int  DEPTH = 1024;
  localparam real PI    = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena_in;
  logic signed [11:0] X_in;
  logic              valid_out;
  logic              sop_out;
  logic signed [8:0] x_out;

  idct_1d dut (
    .clk       (clk),
    .rst       (rst),
    .ena_in    (ena_in),
    .X_in      (X_in),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .x_out     (x_out)
  );

  always #5 clk = ~clk;

  int cyc;
  int mk;
  int mbuf [8];
  bit exp_valid_at [DEPTH];
  int exp_x_at     [DEPTH];
  bit exp_sop_at   [DEPTH];
  bit exp_rst_at   [DEPTH];

  int checks;
  int errors;
  int last_x;
  int cap [8];
  int cap_idx;
  int run_len;
  int max_run;

  int dc   [8] = '{64, 0, 0, 0, 0, 0, 0, 0};
  int ac1  [8] = '{0, 100, 0, 0, 0, 0, 0, 0};
  int satp [8] = '{2047, 0, 0, 0, 0, 0, 0, 0};
  int satn [8] = '{-2048, 0, 0, 0, 0, 0, 0, 0};
  int mix  [8] = '{-300, 45, -120, 77, 500, -9, 33, -1000};
  int mix2 [8] = '{410, -256, 18, 90, -333, 7, -64, 121};

  function automatic int model_coef(input int n, input int k);
    real w;
    real v;
    w = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
    v = 512.0 * w * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  function automatic int model_sample(input int xs[8], input int n);
    longint s;
    int     y;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      s += longint'(xs[k]) * longint'(model_coef(n, k));
    end
    y = int'($floor((real'(s) + 256.0) / 512.0));
    if (y > 255)  y = 255;
    if (y < -256) y = -256;
    return y;
  endfunction

  // Input-side model: collects each block and schedules its 8 samples by cycle number.
  always @(posedge clk) begin : model
    int c;
    int xs [8];
    c = cyc + 1;
    cyc <= c;
    if (!rst) begin
      mk <= 0;
      if (c < DEPTH) exp_rst_at[c] <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= c) exp_valid_at[i] <= 1'b0;
      end
    end else if (ena_in) begin
      mbuf[mk] <= int'(X_in);
      mk <= (mk + 1) % 8;
      if (mk == 7) begin
        for (int i = 0; i < 7; i++) xs[i] = mbuf[i];
        xs[7] = int'(X_in);
        for (int n = 0; n < 8; n++) begin
          if (c + n < DEPTH) begin
            exp_valid_at[c+n] <= 1'b1;
            exp_x_at[c+n]     <= model_sample(xs, n);
            exp_sop_at[c+n]   <= (n == 0);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, got, expv);
    end
  endtask

  task automatic check_cycle();
    int c;
    c = cyc;
    if (c >= DEPTH) begin
      chk("cycle_budget", c, DEPTH - 1);
      return;
    end
    if (exp_rst_at[c]) last_x = 0;
    chk("valid_out", int'(valid_out), int'(exp_valid_at[c]));
    if (exp_valid_at[c]) begin
      chk("x_out", int'(x_out), exp_x_at[c]);
      chk("sop_out", int'(sop_out), int'(exp_sop_at[c]));
      last_x = exp_x_at[c];
    end else begin
      chk("sop_idle", int'(sop_out), 0);
      chk("x_hold", int'(x_out), last_x);
    end
    if (valid_out) begin
      if (sop_out) cap_idx = 0;
      if (cap_idx < 8) cap[cap_idx] = int'(x_out);
      cap_idx++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    $display("cycle %0d: rst=%0b ena=%0b X=%0d -> valid=%0b sop=%0b x=%0d",
             c, rst, ena_in, X_in, valid_out, sop_out, x_out);
  endtask

  task automatic tick(input logic r, input logic e, input logic signed [11:0] x);
    rst    = r;
    ena_in = e;
    X_in   = x;
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic send_block(input int xs[8], input bit gap);
    for (int i = 0; i < 8; i++) cap[i] = 9999;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1, 12'(xs[k]));
      if (gap && k < 7) begin
        tick(1'b1, 1'b0, 12'sh5A5);
        tick(1'b1, 1'b0, -12'sd77);
      end
    end
    chk("first_valid_latency", int'(valid_out), 1);
    chk("first_sop", int'(sop_out), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 12'sd0);
  endtask

  task automatic check_all(input string name, input int expv);
    for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", name, i), cap[i], expv);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    ena_in = 1'b1;
    X_in   = 12'sh123;

    tick(1'b0, 1'b1, 12'sh123);
    tick(1'b0, 1'b1, -12'sd5);
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_sop", int'(sop_out), 0);
    chk("reset_x", int'(x_out), 0);

    chk("model_c00", model_coef(0, 0), 181);
    chk("model_c01", model_coef(0, 1), 251);
    chk("model_c71", model_coef(7, 1), -251);
    chk("model_c34", model_coef(3, 4), 181);
    chk("model_dc", model_sample(dc, 4), 23);
    chk("model_ac1_0", model_sample(ac1, 0), 49);
    chk("model_ac1_7", model_sample(ac1, 7), -49);
    chk("model_satp", model_sample(satp, 3), 255);
    chk("model_satn", model_sample(satn, 6), -256);

    send_block(dc, 1'b0);
    idle(10);
    check_all("dc", 23);

    send_block(ac1, 1'b0);
    idle(10);
    chk("ac1_x0", cap[0], 49);
    chk("ac1_x7", cap[7], -49);

    send_block(satp, 1'b0);
    idle(10);
    check_all("satp", 255);

    send_block(satn, 1'b0);
    idle(10);
    check_all("satn", -256);

    send_block(dc, 1'b1);
    idle(10);
    check_all("gapped_dc", 23);

    max_run = 0;
    send_block(dc, 1'b0);
    send_block(ac1, 1'b0);
    send_block(mix, 1'b0);
    idle(12);
    chk("b2b_run", max_run, 24);

    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 12'(mix2[k]));
    tick(1'b0, 1'b1, 12'sd55);
    chk("rst_a_valid", int'(valid_out), 0);
    chk("rst_a_x", int'(x_out), 0);

    send_block(mix2, 1'b0);
    tick(1'b1, 1'b1, 12'sd7);
    tick(1'b1, 1'b1, -12'sd9);
    tick(1'b0, 1'b0, 12'sd0);
    chk("rst_b_valid", int'(valid_out), 0);
    chk("rst_b_x", int'(x_out), 0);
    idle(3);

    send_block(dc, 1'b0);
    idle(10);
    check_all("post_reset_dc", 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
